// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NUM_REQ requesters.
// Optional done-watchdog is compiled in when ALU_ARB_TIMEOUT_EN is defined.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*8-1:0]   req_a,
    input  logic [NUM_REQ*8-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]   req_opcode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   alu_start,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [2:0]             alu_opcode,
    input  logic [15:0]            alu_result,
    input  logic                   alu_done,
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]      alu_opcode_q, alu_opcode_d;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    int unsigned     cand;
    int unsigned     grant_sel;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            rsp_err_q, rsp_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Search upward from the slot after the last grant, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
        grant_sel = 32'(grant_idx);
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == StIdle && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
`ifdef ALU_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d      = StIssue;
                    last_grant_d = grant_idx;
                    rsp_id_d     = grant_idx;
                    alu_a_d      = req_a[grant_sel*8 +: 8];
                    alu_b_d      = req_b[grant_sel*8 +: 8];
                    alu_opcode_d = req_opcode[grant_sel*3 +: 3];
                end
            end
            StIssue: begin
                // alu_done may still be asserted from the previous op; ignore it.
                state_d = StWait;
`ifdef ALU_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            StWait: begin
                if (alu_done) begin
                    state_d      = StResp;
                    rsp_result_d = alu_result;
`ifdef ALU_ARB_TIMEOUT_EN
                    rsp_err_d    = 1'b0;
                end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = StResp;
                    rsp_result_d = 16'h0000;
                    rsp_err_d    = 1'b1;
                end else begin
                    tmo_cnt_d    = tmo_cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid  = (state_q == StResp);
    assign alu_start  = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter; the bench plays the ALU.
module tb_alu_req_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_opcode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        alu_start;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_req_arbiter #(
        .NUM_REQ        (4),
        .ID_W           (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Called at the negedge of the ISSUE cycle; returns at the negedge of the first RESP cycle.
    task automatic alu_done_after(input int k, input logic [15:0] res);
        repeat (k + 1) @(negedge clk);
        alu_done   = 1'b1;
        alu_result = res;
        @(negedge clk);
        alu_done   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0;
        rsp_ready = 1'b0; alu_done = 1'b0; alu_result = '0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_a, alu_b,
             alu_opcode, busy} !== '0)
            $display("FAIL reset_outputs got=%h exp=0", {req_ready, rsp_valid, rsp_id,
                     rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_opcode, busy});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        req_valid = 4'b0001; req_a[7:0] = 8'h12; req_b[7:0] = 8'h34; req_opcode[2:0] = 3'b001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if ({alu_start, alu_a, alu_b, alu_opcode, busy} !== {1'b1, 8'h12, 8'h34, 3'b001, 1'b1})
            $display("FAIL single_issue got=%b/%h/%h/%b/%b exp=1/12/34/001/1",
                     alu_start, alu_a, alu_b, alu_opcode, busy);
        else n_pass++;
        alu_done_after(1, 16'h0046);
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_err, alu_start} !== {1'b1, 2'd0, 16'h0046, 2'b00})
            $display("FAIL single_resp got=%b/%0d/%h/%b/%b exp=1/0/0046/0/0",
                     rsp_valid, rsp_id, rsp_result, rsp_err, alu_start);
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00)
            $display("FAIL single_idle got=%b%b exp=00", rsp_valid, busy);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        int         exp_id;
        test_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'(i + 5);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            exp_id  = n % 4;
            exp_rdy = 4'b0001 << exp_id;
            n_checks++;
            if (req_ready !== exp_rdy)
                $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready, exp_rdy);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (alu_a !== 8'(exp_id + 1))
                $display("FAIL rr_operand%0d got=%h exp=%h", n, alu_a, 8'(exp_id + 1));
            else n_pass++;
            alu_done_after(1, 16'(n + 16'h0100));
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, req_ready} !==
                {1'b1, 2'(exp_id), 16'(n + 16'h0100), 4'b0000})
                $display("FAIL rr_resp%0d got=%b/%0d/%h/%b exp=1/%0d/%h/0000", n, rsp_valid,
                         rsp_id, rsp_result, req_ready, exp_id, 16'(n + 16'h0100));
            else n_pass++;
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_multiply;
        logic hold_ok;
        req_valid = 4'b0100; req_a[23:16] = 8'hFF; req_b[23:16] = 8'hFF; req_opcode[8:6] = 3'b010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL mul_ready got=%b exp=0100", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = '0; req_a[23:16] = 8'h00; req_b[23:16] = 8'h00;
        // Stale done during ISSUE must be ignored.
        alu_done = 1'b1; alu_result = 16'hDEAD;
        @(negedge clk);
        alu_done = 1'b0;
        n_checks++;
        if ({rsp_valid, busy, alu_start} !== 3'b010)
            $display("FAIL mul_stale_done got=%b%b%b exp=010", rsp_valid, busy, alu_start);
        else n_pass++;
        hold_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ({alu_a, alu_b, alu_opcode, rsp_valid} !== {8'hFF, 8'hFF, 3'b010, 1'b0})
                hold_ok = 1'b0;
            @(negedge clk);
        end
        alu_done = 1'b1; alu_result = 16'hFE01;
        if ({alu_a, alu_b, alu_opcode, rsp_valid} !== {8'hFF, 8'hFF, 3'b010, 1'b0})
            hold_ok = 1'b0;
        n_checks++;
        if (hold_ok !== 1'b1) $display("FAIL mul_hold got=%b exp=1", hold_ok);
        else n_pass++;
        @(negedge clk);
        alu_done = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd2, 16'hFE01})
            $display("FAIL mul_resp got=%b/%0d/%h exp=1/2/fe01", rsp_valid, rsp_id, rsp_result);
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        test_reset();
        req_valid = 4'b0001; req_a[7:0] = 8'h55; req_b[7:0] = 8'h0A; req_opcode[2:0] = 3'b011;
        @(negedge clk);
        req_valid = 4'b0010; req_a[15:8] = 8'h77; req_b[15:8] = 8'h11; req_opcode[5:3] = 3'b100;
        alu_done_after(1, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, req_ready} !== {1'b1, 2'd0, 16'h1234, 4'b0000})
                $display("FAIL bp_hold%0d got=%b/%0d/%h/%b exp=1/0/1234/0000", i, rsp_valid,
                         rsp_id, rsp_result, req_ready);
            else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready} !== 5'b00010)
            $display("FAIL bp_next_grant got=%b/%b exp=0/0010", rsp_valid, req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if ({alu_start, alu_a, alu_b, alu_opcode} !== {1'b1, 8'h77, 8'h11, 3'b100})
            $display("FAIL bp_req1_issue got=%b/%h/%h/%b exp=1/77/11/100",
                     alu_start, alu_a, alu_b, alu_opcode);
        else n_pass++;
        alu_done_after(1, 16'h0088);
        n_checks++;
        if ({rsp_id, rsp_result} !== {2'd1, 16'h0088})
            $display("FAIL bp_req1_resp got=%0d/%h exp=1/0088", rsp_id, rsp_result);
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        req_valid = 4'b1000; req_a[31:24] = 8'h9C; req_b[31:24] = 8'h01; req_opcode[11:9] = 3'b101;
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, rsp_id, alu_a} !== {1'b1, 2'd3, 8'h9C})
            $display("FAIL rstmid_wait got=%b/%0d/%h exp=1/3/9c", busy, rsp_id, alu_a);
        else n_pass++;
        req_valid = 4'b1001; req_a[7:0] = 8'h21;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_a, alu_b,
             alu_opcode, busy} !== '0)
            $display("FAIL rstmid_async got=%h exp=0", {req_ready, rsp_valid, rsp_id,
                     rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_opcode, busy});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, alu_start} !== 5'b00010)
            $display("FAIL rstmid_priority got=%b/%b exp=0001/0", req_ready, alu_start);
        else n_pass++;
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if ({alu_start, alu_a, rsp_id} !== {1'b1, 8'h21, 2'd0})
            $display("FAIL rstmid_issue got=%b/%h/%0d exp=1/21/0", alu_start, alu_a, rsp_id);
        else n_pass++;
        alu_done_after(1, 16'h0001);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        alu_done_after(7, 16'hABCD);
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_result} !== {2'b10, 16'hABCD})
            $display("FAIL tmo_done_at_limit got=%b/%b/%h exp=1/0/abcd",
                     rsp_valid, rsp_err, rsp_result);
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b01)
            $display("FAIL tmo_early got=%b%b exp=01", rsp_valid, busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_result} !== {2'b11, 16'h0000})
            $display("FAIL tmo_expire got=%b/%b/%h exp=1/1/0000",
                     rsp_valid, rsp_err, rsp_result);
        else n_pass++;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_multiply();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
